// File: rtl/arp_rx.sv
// arp_rx: receive-side ARP parser; checks Ethernet/ARP header and captures sender MAC/IP.
// Ports: arp_rx_clk/rstn (sync, active low); arp_rx_valid/arp_rx_data byte stream in;
// arp_rx_done/arp_rx_err one-cycle pulses; arp_rx_op, src_mac, src_ip held results.
module arp_rx #(
  parameter logic [47:0] FPGA_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] FPGA_IP  = 32'hc0_a8_00_03
) (
  input  logic        arp_rx_clk,
  input  logic        rstn,
  input  logic        arp_rx_valid,
  input  logic [7:0]  arp_rx_data,
  output logic        arp_rx_done,
  output logic        arp_rx_op,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic        arp_rx_err
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, RX_END, DROP} state_t;
  localparam logic [71:0] FIX = 72'h0806_0001_0800_06_04_00;
  state_t state_q, state_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic [5:0] cnt_q, cnt_d;
  logic m_q, m_d, b_q, b_d, m_n, b_n, bad;
  logic sop_q, sop_d, pend_q, pend_d;
  logic [47:0] smac_q, smac_d, src_mac_q, src_mac_d, ms;
  logic [31:0] sip_q, sip_d, src_ip_q, src_ip_d, is_;
  logic [71:0] fs;
  logic done_q, done_d, err_q, err_d, op_q, op_d;
  always_comb begin
    ms = FPGA_MAC << {cnt_q, 3'b0};
    fs = FIX << {cnt_q - 6'd12, 3'b0};
    is_ = FPGA_IP << {cnt_q - 6'd38, 3'b0};
    // dst MAC stays acceptable while either the unicast or broadcast match survives
    m_n = (cnt_q == 6'd0 || m_q) && arp_rx_data == ms[47:40];
    b_n = (cnt_q == 6'd0 || b_q) && arp_rx_data == 8'hff;
    bad = cnt_q < 6'd6 ? !(m_n || b_n) :
          (cnt_q >= 6'd12 && cnt_q <= 6'd20) ? arp_rx_data != fs[71:64] :
          cnt_q == 6'd21 ? (arp_rx_data != 8'h01 && arp_rx_data != 8'h02) :
          cnt_q >= 6'd38 ? arp_rx_data != is_[31:24] : 1'b0;
    state_d = state_q;
    pcnt_d = pcnt_q;
    cnt_d = cnt_q;
    m_d = m_q;
    b_d = b_q;
    sop_d = sop_q;
    smac_d = smac_q;
    sip_d = sip_q;
    pend_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    op_d = op_q;
    src_mac_d = src_mac_q;
    src_ip_d = src_ip_q;
    case (state_q)
      IDLE: if (arp_rx_valid) begin
        state_d = arp_rx_data == 8'h55 ? PREAMBLE : DROP;
        pcnt_d = 3'd1;
      end
      PREAMBLE: if (!arp_rx_valid) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else if (arp_rx_data == 8'h55) begin
        pcnt_d = pcnt_q == 3'd7 ? 3'd7 : pcnt_q + 3'd1;
      end else if (arp_rx_data == 8'hd5 && pcnt_q >= 3'd6) begin
        state_d = HEADER;
        cnt_d = 6'd0;
      end else begin
        state_d = DROP;
        err_d = 1'b1;
      end
      HEADER: if (!arp_rx_valid) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else begin
        m_d = m_n;
        b_d = b_n;
        sop_d = cnt_q == 6'd21 ? arp_rx_data == 8'h01 : sop_q;
        smac_d = (cnt_q >= 6'd22 && cnt_q <= 6'd27) ? {smac_q[39:0], arp_rx_data} : smac_q;
        sip_d = (cnt_q >= 6'd28 && cnt_q <= 6'd31) ? {sip_q[23:0], arp_rx_data} : sip_q;
        state_d = bad ? DROP : cnt_q == 6'd41 ? RX_END : HEADER;
        err_d = bad;
        pend_d = !bad && cnt_q == 6'd41;
        cnt_d = (bad || cnt_q == 6'd41) ? cnt_q : cnt_q + 6'd1;
      end
      RX_END: begin
        // results publish one edge after the last target-IP byte is accepted
        done_d = pend_q;
        op_d = pend_q ? sop_q : op_q;
        src_mac_d = pend_q ? smac_q : src_mac_q;
        src_ip_d = pend_q ? sip_q : src_ip_q;
        state_d = arp_rx_valid ? RX_END : IDLE;
      end
      default: state_d = arp_rx_valid ? DROP : IDLE;
    endcase
  end
  always_ff @(posedge arp_rx_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      cnt_q <= '0;
      m_q <= 1'b0;
      b_q <= 1'b0;
      sop_q <= 1'b0;
      smac_q <= '0;
      sip_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      op_q <= 1'b0;
      src_mac_q <= '0;
      src_ip_q <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      b_q <= b_d;
      sop_q <= sop_d;
      smac_q <= smac_d;
      sip_q <= sip_d;
      pend_q <= pend_d;
      done_q <= done_d;
      err_q <= err_d;
      op_q <= op_d;
      src_mac_q <= src_mac_d;
      src_ip_q <= src_ip_d;
    end
  end
  assign arp_rx_done = done_q;
  assign arp_rx_err = err_q;
  assign arp_rx_op = op_q;
  assign src_mac = src_mac_q;
  assign src_ip = src_ip_q;
endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: directed frames against arp_rx with hand-computed expectations.
module tb_arp_rx;
  logic clk = 1'b0;
  logic rstn, valid;
  logic [7:0] data;
  logic done, op, err;
  logic [47:0] mac;
  logic [31:0] ip;
  logic [7:0] fr [80];
  int cur = -1, dcnt = 0, ecnt = 0, d_at = -2, e_at = -2, both = 0;
  int n_chk = 0, n_fail = 0;
  arp_rx dut (
    .arp_rx_clk(clk), .rstn(rstn), .arp_rx_valid(valid), .arp_rx_data(data),
    .arp_rx_done(done), .arp_rx_op(op), .src_mac(mac), .src_ip(ip), .arp_rx_err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (done) begin
      dcnt++;
      d_at = cur;
    end
    if (err) begin
      ecnt++;
      e_at = cur;
    end
    if (done && err) both++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] opc,
                       input logic [47:0] sm, input logic [31:0] si, input logic [31:0] ti);
    logic [335:0] h;
    logic [31:0] fcs;
    h = {dst, 48'h02_00_00_00_00_01, et, 16'h0001, 16'h0800, 8'h06, 8'h04, opc, sm, si, 48'h0, ti};
    fcs = 32'hdeadbeef;
    for (int i = 0; i < 7; i++) fr[i] = 8'h55;
    fr[7] = 8'hd5;
    for (int i = 0; i < 42; i++) begin
      fr[8+i] = h[335:328];
      h = h << 8;
    end
    for (int i = 50; i < 68; i++) fr[i] = 8'h00;
    for (int i = 68; i < 72; i++) begin
      fr[i] = fcs[31:24];
      fcs = fcs << 8;
    end
  endtask
  task automatic clr();
    dcnt = 0;
    ecnt = 0;
    d_at = -2;
    e_at = -2;
  endtask
  task automatic send(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data = fr[i];
      cur = i;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      valid = 1'b0;
      cur = -1;
    end
  endtask
  initial begin
    rstn = 1'b0;
    valid = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_op", 64'(op), 64'd0);
    check("rst_mac", 64'(mac), 64'd0);
    check("rst_ip", 64'(ip), 64'd0);
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h00aabbccddee, 32'hc0a80002, 32'hc0a80003);
    send(72, 3);
    check("t1_done_cnt", 64'(dcnt), 64'd1);
    check("t1_err_cnt", 64'(ecnt), 64'd0);
    check("t1_done_at", 64'(d_at), 64'd50);
    check("t1_op", 64'(op), 64'd1);
    check("t1_mac", 64'(mac), 64'h00aabbccddee);
    check("t1_ip", 64'(ip), 64'hc0a80002);
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h001122334499, 32'hc0a80077, 32'hc0a80009);
    send(72, 3);
    check("t3_err_cnt", 64'(ecnt), 64'd1);
    check("t3_err_at", 64'(e_at), 64'd49);
    check("t3_done_cnt", 64'(dcnt), 64'd0);
    check("t3_op", 64'(op), 64'd1);
    check("t3_mac", 64'(mac), 64'h00aabbccddee);
    check("t3_ip", 64'(ip), 64'hc0a80002);
    clr();
    build(48'h001122334455, 16'h0806, 16'h0002, 48'h665544332211, 32'h0a000001, 32'hc0a80003);
    send(72, 3);
    check("t2_done_cnt", 64'(dcnt), 64'd1);
    check("t2_op", 64'(op), 64'd0);
    check("t2_mac", 64'(mac), 64'h665544332211);
    check("t2_ip", 64'(ip), 64'h0a000001);
    clr();
    build(48'h001122334456, 16'h0806, 16'h0001, 48'h00aabbccddee, 32'hc0a80002, 32'hc0a80003);
    send(72, 3);
    check("t4a_err_cnt", 64'(ecnt), 64'd1);
    check("t4a_err_at", 64'(e_at), 64'd13);
    check("t4a_done_cnt", 64'(dcnt), 64'd0);
    clr();
    build(48'hffffffffffff, 16'h0800, 16'h0001, 48'h00aabbccddee, 32'hc0a80002, 32'hc0a80003);
    send(72, 3);
    check("t4b_err_cnt", 64'(ecnt), 64'd1);
    check("t4b_err_at", 64'(e_at), 64'd21);
    check("t4b_done_cnt", 64'(dcnt), 64'd0);
    check("t4b_mac", 64'(mac), 64'h665544332211);
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80005, 32'hc0a80003);
    send(33, 1);
    send(72, 3);
    check("t5_err_cnt", 64'(ecnt), 64'd1);
    check("t5_done_cnt", 64'(dcnt), 64'd1);
    check("t5_mac", 64'(mac), 64'h0a0b0c0d0e0f);
    check("t5_ip", 64'(ip), 64'hc0a80005);
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h00aabbccddee, 32'hc0a80002, 32'hc0a80003);
    send(38, 0);
    @(negedge clk);
    rstn = 1'b0;
    data = fr[38];
    @(negedge clk);
    rstn = 1'b1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_done_cnt", 64'(dcnt), 64'd0);
    check("t6_err_cnt", 64'(ecnt), 64'd0);
    check("t6_mac", 64'(mac), 64'd0);
    check("t6_ip", 64'(ip), 64'd0);
    check("t6_op", 64'(op), 64'd0);
    send(72, 3);
    check("t6b_done_cnt", 64'(dcnt), 64'd1);
    check("t6b_mac", 64'(mac), 64'h00aabbccddee);
    check("t6b_ip", 64'(ip), 64'hc0a80002);
    clr();
    for (int i = 0; i < 5; i++) fr[i] = 8'h55;
    fr[5] = 8'hd5;
    send(12, 3);
    check("short_pre_err_cnt", 64'(ecnt), 64'd1);
    check("short_pre_err_at", 64'(e_at), 64'd5);
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h111111111111, 32'h22222222, 32'hc0a80003);
    fr[0] = 8'haa;
    send(72, 3);
    check("bad_start_err_cnt", 64'(ecnt), 64'd0);
    check("bad_start_done_cnt", 64'(dcnt), 64'd0);
    check("bad_start_mac", 64'(mac), 64'h00aabbccddee);
    check("done_err_exclusive", 64'(both), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
